// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause bit positions and exception codes.
package cp0_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    localparam logic [REG_W-1:0] CP0_BADVADDR = 5'd8;
    localparam logic [REG_W-1:0] CP0_COUNT    = 5'd9;
    localparam logic [REG_W-1:0] CP0_COMPARE  = 5'd11;
    localparam logic [REG_W-1:0] CP0_STATUS   = 5'd12;
    localparam logic [REG_W-1:0] CP0_CAUSE    = 5'd13;
    localparam logic [REG_W-1:0] CP0_EPC      = 5'd14;

    // Status fields
    localparam int unsigned ST_IE    = 0;
    localparam int unsigned ST_EXL   = 1;
    localparam int unsigned ST_IM_LO = 8;
    localparam int unsigned ST_BEV   = 22;

    // Cause fields
    localparam int unsigned CA_EXC_LO = 2;
    localparam int unsigned CA_IP_LO  = 8;
    localparam int unsigned CA_TI     = 30;
    localparam int unsigned CA_BD     = 31;

    // Only IM, EXL and IE are software-writable in Status
    localparam logic [DATA_W-1:0] STATUS_WMASK = 32'h0000_ff03;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [DATA_W-1:0] pack_cause(
        input logic       bd,
        input logic       ti,
        input logic [7:0] ip,
        input logic [4:0] exc_code
    );
        logic [DATA_W-1:0] c;
        c                      = '0;
        c[CA_BD]               = bd;
        c[CA_TI]               = ti;
        c[CA_IP_LO +: 8]       = ip;
        c[CA_EXC_LO +: 5]      = exc_code;
        return c;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled free-running Count with a sticky compare-match flag.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              count_wen,
    input  logic              compare_wen,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] compare,
    output logic              ti
);

    localparam int unsigned       DIV_W    = 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] compare_q, compare_d;
    logic              ti_q, ti_d;
    logic              tick;

    always_comb begin
        div_d     = div_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        tick      = (div_q == DIV_LAST);

        if (count_wen) begin
            count_d = wdata;
            div_d   = '0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
            div_d   = '0;
        end else begin
            div_d   = div_q + DIV_W'(1);
        end

        if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
        // Writing Compare acknowledges the timer interrupt, even against a same-cycle match
        if (compare_wen) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// System coprocessor 0 register file: exception state capture, MFC0/MTC0 access and timer.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [DATA_W-1:0] STATUS_RESET = 32'h0040_0000,
    parameter int unsigned       COUNT_DIV    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        hw_int,
    input  logic [REG_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              wen,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              exp_en,
    input  logic              exl_clean,
    input  logic [DATA_W-1:0] exp_epc,
    input  logic [4:0]        exp_code,
    input  logic [DATA_W-1:0] exp_bad_vaddr,
    input  logic              exp_bad_vaddr_wen,
    input  logic              exp_bd,
    output logic [DATA_W-1:0] epc_address,
    output logic              allow_interrupt,
    output logic [7:0]        interrupt_flag
);

    logic [DATA_W-1:0] status_q, status_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic [DATA_W-1:0] bad_vaddr_q, bad_vaddr_d;
    logic [7:0]        ip_q, ip_d;
    logic [4:0]        exc_code_q, exc_code_d;
    logic              bd_q, bd_d;

    logic              mtc0;
    logic              exl;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] compare;
    logic              ti;

    assign mtc0 = wen & ~exp_en;
    assign exl  = status_q[ST_EXL];

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .count_wen   (mtc0 && (waddr == CP0_COUNT)),
        .compare_wen (mtc0 && (waddr == CP0_COMPARE)),
        .wdata       (wdata),
        .count       (count),
        .compare     (compare),
        .ti          (ti)
    );

    // Next-state: exception commit > ERET > MTC0 on every field
    always_comb begin
        status_d    = status_q;
        epc_d       = epc_q;
        bad_vaddr_d = bad_vaddr_q;
        exc_code_d  = exc_code_q;
        bd_d        = bd_q;
        ip_d        = {hw_int[5] | ti, hw_int[4:0], ip_q[1:0]};

        if (mtc0) begin
            case (waddr)
                CP0_STATUS: status_d  = (wdata & STATUS_WMASK) | (status_q & ~STATUS_WMASK);
                CP0_CAUSE:  ip_d[1:0] = wdata[CA_IP_LO +: 2];
                CP0_EPC:    epc_d     = wdata;
                default:    ;
            endcase
        end

        if (exl_clean) begin
            status_d[ST_EXL] = 1'b0;
        end

        if (exp_en) begin
            status_d[ST_EXL] = 1'b1;
            exc_code_d       = exp_code;
            if (!exl) begin
                epc_d = exp_epc;
                bd_d  = exp_bd;
            end
            if (exp_bad_vaddr_wen) begin
                bad_vaddr_d = exp_bad_vaddr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            status_q    <= STATUS_RESET;
            epc_q       <= '0;
            bad_vaddr_q <= '0;
            ip_q        <= '0;
            exc_code_q  <= '0;
            bd_q        <= 1'b0;
        end else begin
            status_q    <= status_d;
            epc_q       <= epc_d;
            bad_vaddr_q <= bad_vaddr_d;
            ip_q        <= ip_d;
            exc_code_q  <= exc_code_d;
            bd_q        <= bd_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (raddr)
            CP0_BADVADDR: rdata = bad_vaddr_q;
            CP0_COUNT:    rdata = count;
            CP0_COMPARE:  rdata = compare;
            CP0_STATUS:   rdata = status_q;
            CP0_CAUSE:    rdata = pack_cause(bd_q, ti, ip_q, exc_code_q);
            CP0_EPC:      rdata = epc_q;
            default:      rdata = '0;
        endcase
    end

    // A same-cycle MTC0 EPC is forwarded so an ERET right behind it sees the new target
    assign epc_address     = (mtc0 && (waddr == CP0_EPC)) ? wdata : epc_q;
    assign allow_interrupt = status_q[ST_IE] & ~exl;
    assign interrupt_flag  = ip_q & status_q[ST_IM_LO +: 8];

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: expectations are queued at stimulus time and popped at sampling.
module tb_cp0_regfile;
    import cp0_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  hw_int;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        exp_en;
    logic        exl_clean;
    logic [31:0] exp_epc;
    logic [4:0]  exp_code;
    logic [31:0] exp_bad_vaddr;
    logic        exp_bad_vaddr_wen;
    logic        exp_bd;
    logic [31:0] epc_address;
    logic        allow_interrupt;
    logic [7:0]  interrupt_flag;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] v;
    bit          seen;

    cp0_regfile #(
        .STATUS_RESET (32'h0040_0000),
        .COUNT_DIV    (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .hw_int            (hw_int),
        .raddr             (raddr),
        .rdata             (rdata),
        .wen               (wen),
        .waddr             (waddr),
        .wdata             (wdata),
        .exp_en            (exp_en),
        .exl_clean         (exl_clean),
        .exp_epc           (exp_epc),
        .exp_code          (exp_code),
        .exp_bad_vaddr     (exp_bad_vaddr),
        .exp_bad_vaddr_wen (exp_bad_vaddr_wen),
        .exp_bd            (exp_bd),
        .epc_address       (epc_address),
        .allow_interrupt   (allow_interrupt),
        .interrupt_flag    (interrupt_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic expect_val(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            tag = tag_q.pop_front();
            e   = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] val);
        raddr = a;
        #1;
        val = rdata;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        cycle();
        wen   = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0; hw_int = '0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
        exp_en = 1'b0; exl_clean = 1'b0; exp_epc = '0; exp_code = '0;
        exp_bad_vaddr = '0; exp_bad_vaddr_wen = 1'b0; exp_bd = 1'b0;

        // Reset state
        expect_val("rst_status", 32'h0040_0000);
        expect_val("rst_cause", 32'h0);
        expect_val("rst_allow", 32'h0);
        expect_val("rst_flag", 32'h0);
        expect_val("rst_epc_addr", 32'h0);
        repeat (2) cycle();
        rd(CP0_STATUS, v); check(v);
        rd(CP0_CAUSE, v);  check(v);
        check(32'(allow_interrupt));
        check(32'(interrupt_flag));
        check(epc_address);
        rst = 1'b1;

        // Move Compare away from Count so the timer stays quiet
        expect_val("cause_quiet", 32'h0);
        mtc0(CP0_COMPARE, 32'hffff_0000);
        rd(CP0_CAUSE, v); check(v);

        // First exception, EXL was 0
        exp_en = 1'b1; exp_epc = 32'hbfc0_0100; exp_code = EXC_OV; exp_bd = 1'b1;
        expect_val("exc1_epc", 32'hbfc0_0100);
        expect_val("exc1_cause", 32'h8000_0030);
        expect_val("exc1_status", 32'h0040_0002);
        expect_val("exc1_allow", 32'h0);
        cycle();
        exp_en = 1'b0; exp_bd = 1'b0;
        rd(CP0_EPC, v);    check(v);
        rd(CP0_CAUSE, v);  check(v);
        rd(CP0_STATUS, v); check(v);
        check(32'(allow_interrupt));

        // Nested exception keeps EPC and BD, updates ExcCode
        exp_en = 1'b1; exp_epc = 32'h0000_1234; exp_code = EXC_ADEL;
        expect_val("nest_epc", 32'hbfc0_0100);
        expect_val("nest_cause", 32'h8000_0010);
        cycle();
        exp_en = 1'b0;
        rd(CP0_EPC, v);   check(v);
        rd(CP0_CAUSE, v); check(v);

        exl_clean = 1'b1;
        expect_val("eret_status", 32'h0040_0000);
        cycle();
        exl_clean = 1'b0;
        rd(CP0_STATUS, v); check(v);

        // Address-error exception with BadVAddr; same-cycle MTC0 Status dropped
        exp_en = 1'b1; exp_bad_vaddr_wen = 1'b1; exp_bad_vaddr = 32'h8000_0003;
        exp_code = EXC_ADES; exp_epc = 32'h0000_2000;
        wen = 1'b1; waddr = CP0_STATUS; wdata = 32'hffff_ffff;
        expect_val("bva_badvaddr", 32'h8000_0003);
        expect_val("bva_status", 32'h0040_0002);
        expect_val("bva_epc", 32'h0000_2000);
        expect_val("bva_cause", 32'h0000_0014);
        cycle();
        exp_en = 1'b0; exp_bad_vaddr_wen = 1'b0; wen = 1'b0;
        rd(CP0_BADVADDR, v); check(v);
        rd(CP0_STATUS, v);   check(v);
        rd(CP0_EPC, v);      check(v);
        rd(CP0_CAUSE, v);    check(v);
        exl_clean = 1'b1;
        cycle();
        exl_clean = 1'b0;

        // BadVAddr is read-only; unimplemented registers read 0
        expect_val("badvaddr_ro", 32'h8000_0003);
        mtc0(CP0_BADVADDR, 32'h0);
        rd(CP0_BADVADDR, v); check(v);
        expect_val("unimpl_reg", 32'h0);
        mtc0(5'd3, 32'hdead_beef);
        rd(5'd3, v); check(v);

        // Timer interrupt
        mtc0(CP0_COUNT, 32'h0);
        mtc0(CP0_COMPARE, 32'h5);
        expect_val("tmr_status", 32'h0040_8001);
        expect_val("tmr_allow", 32'h1);
        mtc0(CP0_STATUS, 32'h0000_8001);
        rd(CP0_STATUS, v); check(v);
        check(32'(allow_interrupt));
        expect_val("tmr_flag", 32'h80);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (interrupt_flag == 8'h80) begin
                seen = 1'b1;
                break;
            end
            cycle();
        end
        if (!seen) begin
            $display("FAIL tmr_timeout interrupt_flag=%h within 40 cycles", interrupt_flag);
        end
        check(32'(interrupt_flag));
        expect_val("tmr_ti_set", 32'h1);
        rd(CP0_CAUSE, v); check(32'(v[CA_TI]));

        expect_val("tmr_ti_clear", 32'h0);
        mtc0(CP0_COMPARE, 32'hffff_0000);
        rd(CP0_CAUSE, v); check(32'(v[CA_TI]));
        expect_val("tmr_flag_clear", 32'h0);
        cycle();
        check(32'(interrupt_flag));

        // Count wraps and advances every second cycle
        expect_val("cnt_load", 32'hffff_ffff);
        expect_val("cnt_hold", 32'hffff_ffff);
        expect_val("cnt_wrap", 32'h0);
        mtc0(CP0_COUNT, 32'hffff_ffff);
        rd(CP0_COUNT, v); check(v);
        cycle();
        rd(CP0_COUNT, v); check(v);
        cycle();
        rd(CP0_COUNT, v); check(v);

        // Hardware interrupt: one cycle of latency through Cause.IP
        hw_int = 6'h01;
        wen = 1'b1; waddr = CP0_STATUS; wdata = 32'h0000_0401;
        expect_val("hw_flag_pre", 32'h0);
        expect_val("hw_flag_post", 32'h04);
        #1;
        check(32'(interrupt_flag));
        cycle();
        wen = 1'b0;
        check(32'(interrupt_flag));

        expect_val("sw_ip_cause", 32'h0000_0714);
        mtc0(CP0_CAUSE, 32'h0000_0300);
        rd(CP0_CAUSE, v); check(v);

        // MTC0 EPC forwarded to the ERET target in the same cycle
        wen = 1'b1; waddr = CP0_EPC; wdata = 32'h0000_0040; exl_clean = 1'b1;
        expect_val("fwd_epc_addr", 32'h0000_0040);
        expect_val("fwd_epc_reg", 32'h0000_0040);
        #1;
        check(epc_address);
        cycle();
        wen = 1'b0; exl_clean = 1'b0;
        rd(CP0_EPC, v); check(v);

        // No forwarding when an exception commits in the same cycle
        wen = 1'b1; waddr = CP0_EPC; wdata = 32'h0000_0099;
        exp_en = 1'b1; exp_epc = 32'h0000_0080; exp_code = EXC_SYS;
        expect_val("nofwd_epc_addr", 32'h0000_0040);
        expect_val("nofwd_epc_reg", 32'h0000_0080);
        expect_val("nofwd_status", 32'h0040_0403);
        #1;
        check(epc_address);
        cycle();
        wen = 1'b0; exp_en = 1'b0;
        rd(CP0_EPC, v);    check(v);
        rd(CP0_STATUS, v); check(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
